// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the five-stage pipeline datapath and the hazard controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REG_W-1:0] WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE, BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic             CntClr;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
    output MemReqM, MemReadyM, CntClr,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
    input  MemReqM, MemReadyM, CntClr,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stalls, branch flushes,
// data-memory wait sequencing with timeout error, and saturating hazard counters.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_ERROR} state_t;

  state_t             state, state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  logic       mem_wait, ld_stall, timeout;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, branch_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;

  assign mem_wait = hz.MemReqM && !hz.MemReadyM;
  assign ld_stall = hz.MemToRegE && hz.RegWriteE &&
                    (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
  assign timeout  = mem_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:     if (timeout) state_next = ST_ERROR;
                  else if (mem_wait) state_next = ST_MEMWAIT;
      ST_MEMWAIT: if (timeout) state_next = ST_ERROR;
                  else if (!mem_wait) state_next = ST_RUN;
      ST_ERROR:   state_next = ST_ERROR;
      default:    state_next = ST_RUN;
    endcase
  end

  // Priority: reset > error > memory wait > taken branch > load-use.
  always_comb begin
    stall_f = 1'b0;  stall_d = 1'b0;  stall_e = 1'b0;  stall_m = 1'b0;
    flush_d = 1'b0;  flush_e = 1'b0;  flush_w = 1'b0;
    branch_flush = 1'b0;
    mem_err = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!RESET_N) begin
      flush_d = 1'b1;  flush_e = 1'b1;  flush_w = 1'b1;
    end else if (state == ST_ERROR) begin
      stall_f = 1'b1;  stall_d = 1'b1;  stall_e = 1'b1;  stall_m = 1'b1;
      flush_w = 1'b1;
      mem_err = 1'b1;
    end else begin
      if (hz.RegWriteM && hz.WA3M == hz.RA1E)      fwd_a = 2'b10;
      else if (hz.RegWriteW && hz.WA3W == hz.RA1E) fwd_a = 2'b01;
      if (hz.RegWriteM && hz.WA3M == hz.RA2E)      fwd_b = 2'b10;
      else if (hz.RegWriteW && hz.WA3W == hz.RA2E) fwd_b = 2'b01;

      if (mem_wait) begin
        stall_f = 1'b1;  stall_d = 1'b1;  stall_e = 1'b1;  stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.BranchTakenE) begin
        flush_d = 1'b1;  flush_e = 1'b1;
        branch_flush = 1'b1;
      end else if (ld_stall) begin
        stall_f = 1'b1;  stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (!mem_wait)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.CntClr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.MemErr    = mem_err;
  assign hz.StallCnt  = stall_cnt;
  assign hz.FlushCnt  = flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage pipelined CPU (F, D, E, M, W). It drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding muxes. It sequences load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a memory-timeout error state and saturating hazard performance counters.

## Interface
Parameters:
- REG_W, 5, register-address width (RA/WA fields)
- MEM_TIMEOUT, 64, consecutive not-ready memory cycles before the error state (legal range 2..2^16-1)
- CNT_W, 16, width of the performance counters

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  REG_W  source registers of the instruction in D
- RA1E, RA2E  in  REG_W  source registers of the instruction in E
- WA3E, WA3M, WA3W  in  REG_W  destination registers in E, M and W
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables per stage
- MemToRegE  in  1  instruction in E is a load
- BranchTakenE  in  1  branch resolved as taken in E
- MemReqM  in  1  M-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- CntClr  in  1  synchronous clear of both performance counters
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E and E/M registers
- FlushD, FlushE, FlushW  out  1  load a bubble into the F/D, D/E and M/W registers
- ForwardAE, ForwardBE  out  2  E operand select: 00 register file, 01 W result, 10 M ALU result
- MemErr  out  1  memory timeout; sticky until reset
- StallCnt, FlushCnt  out  CNT_W  saturating hazard counters

## Operation
- FSM states: RUN, MEMWAIT, ERROR. Stall, flush and forward outputs are combinational from the inputs and the current state.
- Forwarding (RUN and MEMWAIT): ForwardAE = 10 if RegWriteM && WA3M==RA1E; otherwise 01 if RegWriteW && WA3W==RA1E; otherwise 00. M has priority over W. ForwardBE uses the same rule with RA2E. No register index is special-cased.
- Mem wait: MemWait = MemReqM && !MemReadyM.
  - When MemWait=1: StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=0 during MemWait. A pending BranchTakenE stays held in E and its flush takes effect in the first cycle MemReadyM=1.
- Load-use: LdStall = MemToRegE && RegWriteE && (WA3E==RA1D || WA3E==RA2D).
  - Evaluated only when MemWait=0 and BranchTakenE=0.
  - When asserted: StallF=StallD=1 and FlushE=1, for one cycle.
- Branch: BranchTakenE && !MemWait gives FlushD=FlushE=1 with no stall. This cancels any simultaneous LdStall, because the D instruction is discarded.
- Priority: ERROR > MemWait > BranchTakenE > LdStall > none (all stalls and flushes 0).
- FSM transitions:
  - RUN to MEMWAIT on MemWait.
  - MEMWAIT to RUN when MemReadyM=1 or MemReqM=0.
  - RUN/MEMWAIT to ERROR at the edge ending the MEM_TIMEOUT-th consecutive MemWait cycle.
  - ERROR has no exit except reset.
- wait_cnt:
  - Holds the number of consecutive MemWait cycles.
  - Cleared on any cycle with MemWait=0.
  - Increments otherwise, up to MEM_TIMEOUT.
- ERROR state outputs: MemErr=1; all four stalls=1; FlushW=1; FlushD=FlushE=0; forwards=00.
- StallCnt increments in every cycle with StallF=1, including ERROR.
- FlushCnt increments in every cycle with a branch flush.
- Both counters saturate at all-ones. CntClr=1 zeroes them at the edge, and clear takes priority over increment.

## Timing
- Reset (RESET_N=0, asynchronous, takes effect immediately):
  - State RUN, wait_cnt=0, MemErr=0, StallCnt=FlushCnt=0.
  - Combinational outputs are forced while reset is low: all stalls=0, FlushD=FlushE=FlushW=1, forwards=00.
  - Reset during MEMWAIT or ERROR aborts the wait; the first cycle after release is RUN.
- Stall, flush and forward outputs have zero latency: they respond in the same cycle as their inputs.
- MemErr asserts in the cycle after the MEM_TIMEOUT-th not-ready cycle.
- Counters update at the edge that ends the qualifying cycle.
- Load-use stall lasts exactly one cycle for a single load followed by a dependent instruction. Back-to-back loads with dependencies each stall one cycle.
- MemReadyM=1 in the first MemReqM cycle: no stall, no state change.

## Test plan
- Forwarding: RegWriteM=1, WA3M=3; RegWriteW=1, WA3W=3; RA1E=3, RA2E=7 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> exactly one cycle of StallF=StallD=FlushE=1; StallCnt goes from 0 to 1.
- Branch over load-use: the load-use case above plus BranchTakenE=1 -> FlushD=FlushE=1, StallF=0, FlushCnt+1.
- Mem wait with pending branch: MemReqM=1, MemReadyM=0 for 4 cycles with BranchTakenE=1:
  - Those 4 cycles: all stalls=1, FlushW=1, FlushD=FlushE=0.
  - Cycle 5, MemReadyM=1: stalls 0, FlushD=FlushE=1.
  - StallCnt=4, FlushCnt=1.
- Timeout with MEM_TIMEOUT=8: MemReadyM held 0 -> MemErr=1 from cycle 9 and all stalls stay 1. Dropping MemReqM keeps ERROR. Pulsing RESET_N low returns to RUN with MemErr=0 and counters 0.
- Saturation/clear: CNT_W=4, stall for 20 cycles -> StallCnt=15. CntClr together with a stall cycle -> StallCnt=0.
